lzc_seq: RTL and testbench

LZC_SEQ -- requirements
Module: lzc_seq

---
 rtl/lzc_pkg.sv | 15 +
 rtl/lzc.sv | 23 ++
 rtl/lzc_seq.sv | 141 ++++++++++++++
 tb/tb_lzc_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// Shared FSM state type and width helper for the sequential leading-zero counter.
package lzc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to hold a count in the range 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter over a WIDTH-bit slice; all-zero input yields WIDTH.
module lzc
    import lzc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]            in_bits,
    output logic [cnt_width(WIDTH)-1:0] zero_cnt
);

    localparam int CW = cnt_width(WIDTH);

    always_comb begin
        // NOTE: default first so every path assigns zero_cnt; no latch is inferred.
        zero_cnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_bits[i]) begin
                zero_cnt = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lzc_seq.sv
// Sequential leading-zero counter/normaliser scanning CHUNK bits per cycle.
// Define LZC_SEQ_EARLY_EXIT_EN to leave SCAN as soon as the first set bit is found.
module lzc_seq
    import lzc_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic [WIDTH-1:0]            InNum,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [cnt_width(WIDTH)-1:0] ZeroCnt,
    output logic [WIDTH-1:0]            NormNum,
    output logic                        Busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(WIDTH);
    localparam int CCNT_W = cnt_width(CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (((WIDTH % CHUNK) != 0) || (CHUNK < 2)) begin : g_param_check
        $error("lzc_seq: WIDTH must be a multiple of CHUNK and CHUNK must be >= 2");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               found_q, found_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               scan_exit;
    logic [CCNT_W-1:0]  chunk_cnt;

    lzc #(
        .WIDTH (CHUNK)
    ) u_lzc (
        .in_bits  (work_q[WIDTH-1 -: CHUNK]),
        .zero_cnt (chunk_cnt)
    );

    // A chunk count of CHUNK means all-zero: shift and count by the full chunk.
    // Any smaller count lands the first set bit at the MSB, so one rule covers both.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        count_d     = count_q;
        idx_d       = idx_q;
        found_d     = found_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;
        scan_exit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (InValid && in_ready_q) begin
                    work_d     = InNum;
                    count_d    = '0;
                    idx_d      = '0;
                    found_d    = 1'b0;
                    state_d    = SCAN;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                end
            end

            SCAN: begin
                if (!found_q) begin
                    count_d = count_q + CNT_W'(chunk_cnt);
                    work_d  = work_q << chunk_cnt;
                    found_d = (chunk_cnt != CCNT_W'(CHUNK));
                end
                idx_d = idx_q + IDX_W'(1);
`ifdef LZC_SEQ_EARLY_EXIT_EN
                scan_exit = found_d || (idx_q == LAST_IDX);
`else
                scan_exit = (idx_q == LAST_IDX);
`endif
                if (scan_exit) begin
                    idx_d       = idx_q;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end

            DONE: begin
                if (OutReady) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            found_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            work_q      <= work_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            found_q     <= found_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign Busy     = busy_q;
    assign ZeroCnt  = count_q;
    assign NormNum  = work_q;

endmodule

// File: tb/tb_lzc_seq.sv
// Self-checking bench for lzc_seq: directed corner cases plus randomized operands vs a behavioural model.
module tb_lzc_seq;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(WIDTH + 1);
`ifdef LZC_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk      = 1'b0;
    logic             reset_n  = 1'b0;
    logic             InValid  = 1'b0;
    logic             OutReady = 1'b0;
    logic [WIDTH-1:0] InNum    = '0;
    logic             InReady;
    logic             OutValid;
    logic             Busy;
    logic [CW-1:0]    ZeroCnt;
    logic [WIDTH-1:0] NormNum;

    int checks = 0;
    int errors = 0;

    // Model state: one operation in flight, its expected results and OutValid cycle.
    bit          pending   = 1'b0;
    int          cyc_since = 0;
    int          exp_lat   = 0;
    int          exp_lz    = 0;
    logic [63:0] exp_norm  = '0;

    always #5 clk = ~clk;

    lzc_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .InNum    (InNum),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ZeroCnt  (ZeroCnt),
        .NormNum  (NormNum),
        .Busy     (Busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_lz(input logic [63:0] x);
        for (int i = 63; i >= 0; i--) begin
            if (x[i]) return 63 - i;
        end
        return 64;
    endfunction

    // Cycle (counting the handshake edge as 0) in which OutValid first rises.
    function automatic int ref_lat(input int lz);
        if (!EARLY || lz >= WIDTH) return NCHUNK + 1;
        return (lz / CHUNK) + 2;
    endfunction

    always @(negedge clk) begin
        if (pending) cyc_since++;
        if (!reset_n) begin
            check("rst_zerocnt", 64'(ZeroCnt), 64'd0);
            check("rst_normnum", NormNum, 64'd0);
        end
        check("out_valid", 64'(OutValid), 64'(pending && cyc_since >= exp_lat));
        check("busy", 64'(Busy), 64'(pending));
        check("in_ready", 64'(InReady), 64'(!pending));
        if (pending && cyc_since >= exp_lat) begin
            check("zero_cnt", 64'(ZeroCnt), 64'(exp_lz));
            check("norm_num", NormNum, exp_norm);
        end
    end

    task automatic do_op(input logic [63:0] x, input int hold, input bit poke,
                         output int lat, output logic [63:0] zc, output logic [63:0] nn);
        @(negedge clk);
        InValid = 1'b1;
        InNum   = x;
        @(posedge clk);
        exp_lz    = ref_lz(x);
        exp_norm  = x << exp_lz;
        exp_lat   = ref_lat(exp_lz);
        cyc_since = 0;
        pending   = 1'b1;
        @(negedge clk);
        if (poke) begin
            InNum = 64'h1;
        end else begin
            InValid = 1'b0;
            InNum   = {$urandom, $urandom};
        end
        lat = 1;
        zc  = '0;
        nn  = '0;
        while (OutValid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            InValid = 1'b0;
            lat++;
        end
        InValid = 1'b0;
        if (lat >= 40) begin
            check("out_valid_timeout", 64'(OutValid), 64'd1);
            pending = 1'b0;
            return;
        end
        zc = 64'(ZeroCnt);
        nn = NormNum;
        repeat (hold) @(negedge clk);
        OutReady = 1'b1;
        @(posedge clk);
        pending = 1'b0;
        @(negedge clk);
        OutReady = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [63:0] zc, nn, x, r;
        int          sh;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(InReady), 64'd1);
        check("rst_out_valid", 64'(OutValid), 64'd0);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op(64'h8000_0000_0000_0000, 0, 1'b0, lat, zc, nn);
        check("msb_zc", zc, 64'd0);
        check("msb_norm", nn, 64'h8000_0000_0000_0000);
        check("msb_lat", 64'(lat), EARLY ? 64'd2 : 64'd5);

        do_op(64'h0000_0000_0001_0000, 3, 1'b1, lat, zc, nn);
        check("mid_zc", zc, 64'd47);
        check("mid_norm", nn, 64'h8000_0000_0000_0000);
        check("mid_lat", 64'(lat), EARLY ? 64'd4 : 64'd5);

        do_op(64'h0, 1, 1'b0, lat, zc, nn);
        check("zero_zc", zc, 64'd64);
        check("zero_norm", nn, 64'd0);
        check("zero_lat", 64'(lat), 64'd5);

        do_op(64'h1, 0, 1'b0, lat, zc, nn);
        check("lsb_zc", zc, 64'd63);
        check("lsb_norm", nn, 64'h8000_0000_0000_0000);
        check("lsb_lat", 64'(lat), 64'd5);

        // Reset during the second SCAN cycle must abandon the operation.
        @(negedge clk);
        InValid = 1'b1;
        InNum   = 64'h0000_00F0_0000_0000;
        @(posedge clk);
        exp_lz    = ref_lz(InNum);
        exp_norm  = InNum << exp_lz;
        exp_lat   = ref_lat(exp_lz);
        cyc_since = 0;
        pending   = 1'b1;
        @(negedge clk);
        InValid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        pending = 1'b0;
        #1;
        check("midrst_out_valid", 64'(OutValid), 64'd0);
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_in_ready", 64'(InReady), 64'd1);
        check("midrst_zerocnt", 64'(ZeroCnt), 64'd0);
        check("midrst_normnum", NormNum, 64'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (8) @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            r  = {$urandom, $urandom};
            sh = $urandom_range(0, 64);
            x  = r >> sh;
            if ($urandom_range(0, 7) == 0) x = '0;
            do_op(x, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, zc, nn);
            check("rand_lat", 64'(lat), 64'(ref_lat(ref_lz(x))));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
